// File: rtl/flag_shadow_stack_if.sv
// Flag-register bus: ALU/control requests in, live flags and shadow-stack status out.
interface flag_shadow_stack_if #(
  parameter int unsigned NFLAGS = 2,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] DIN;
  logic [NFLAGS-1:0] FLG_LD;
  logic [NFLAGS-1:0] FLG_SET;
  logic [NFLAGS-1:0] FLG_CLR;
  logic              SHAD_PUSH;
  logic              SHAD_POP;
  logic [NFLAGS-1:0] FLAGS;
  logic [LvlW-1:0]   SHAD_LVL;
  logic              SHAD_EMPTY;
  logic              SHAD_FULL;
  logic              SHAD_ERR;

  modport master (
    output DIN, FLG_LD, FLG_SET, FLG_CLR, SHAD_PUSH, SHAD_POP,
    input  FLAGS, SHAD_LVL, SHAD_EMPTY, SHAD_FULL, SHAD_ERR
  );

  modport slave (
    input  DIN, FLG_LD, FLG_SET, FLG_CLR, SHAD_PUSH, SHAD_POP,
    output FLAGS, SHAD_LVL, SHAD_EMPTY, SHAD_FULL, SHAD_ERR
  );
endinterface

// File: rtl/flag_shadow_stack.sv
// CPU status-flag register with a LIFO shadow stack saving/restoring flags across
// nested interrupts; sticky error on overflow, underflow or push/pop conflict.
module flag_shadow_stack #(
  parameter int unsigned NFLAGS      = 2,
  parameter int unsigned DEPTH       = 4,
  parameter bit          CLR_ON_PUSH = 1'b0
) (
  input logic                CLK,
  input logic                RST,
  flag_shadow_stack_if.slave bus
);
  localparam int unsigned LvlW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] flags_q, flags_d;
  logic [LvlW-1:0]   lvl_q, lvl_d;
  logic              err_q, err_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [NFLAGS-1:0] stack_d [DEPTH];

  logic              full, empty, push_ok, pop_ok, err_evt;
  logic [NFLAGS-1:0] upd, pop_val;

  assign full    = (lvl_q == LvlW'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign push_ok = bus.SHAD_PUSH & ~bus.SHAD_POP & ~full;
  assign pop_ok  = bus.SHAD_POP & ~bus.SHAD_PUSH & ~empty;
  assign err_evt = (bus.SHAD_PUSH & bus.SHAD_POP) | (bus.SHAD_PUSH & full) |
                   (bus.SHAD_POP & empty);

  always_comb begin
    // Clear beats set beats load, bit by bit.
    upd = (flags_q & ~bus.FLG_LD) | (bus.DIN & bus.FLG_LD);
    upd = upd | bus.FLG_SET;
    upd = upd & ~bus.FLG_CLR;

    pop_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (lvl_q - LvlW'(1) == LvlW'(i)) pop_val = stack_q[i];
    end

    stack_d = stack_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push_ok && lvl_q == LvlW'(i)) stack_d[i] = flags_q;
    end

    if (pop_ok) begin
      flags_d = pop_val;
    end else if (push_ok && CLR_ON_PUSH) begin
      flags_d = '0;
    end else begin
      flags_d = upd;
    end

    lvl_d = lvl_q;
    if (push_ok) lvl_d = lvl_q + LvlW'(1);
    else if (pop_ok) lvl_d = lvl_q - LvlW'(1);

    err_d = err_q | err_evt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flags_q <= '0;
      lvl_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      lvl_q   <= lvl_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are don't-care after reset; only the level qualifies them.
  always_ff @(posedge CLK) begin
    if (!RST) stack_q <= stack_d;
  end

  assign bus.FLAGS      = flags_q;
  assign bus.SHAD_LVL   = lvl_q;
  assign bus.SHAD_EMPTY = empty;
  assign bus.SHAD_FULL  = full;
  assign bus.SHAD_ERR   = err_q;
endmodule

// File: tb/tb_flag_shadow_stack.sv
// Directed bench for flag_shadow_stack: default DUT (a) plus a CLR_ON_PUSH=1 DUT (b).
module tb_flag_shadow_stack;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  flag_shadow_stack_if #(.NFLAGS(2), .DEPTH(4)) ia ();
  flag_shadow_stack_if #(.NFLAGS(2), .DEPTH(4)) ib ();

  flag_shadow_stack #(.NFLAGS(2), .DEPTH(4), .CLR_ON_PUSH(1'b0)) u_dut_a (
    .CLK (clk),
    .RST (rst),
    .bus (ia.slave)
  );

  flag_shadow_stack #(.NFLAGS(2), .DEPTH(4), .CLR_ON_PUSH(1'b1)) u_dut_b (
    .CLK (clk),
    .RST (rst),
    .bus (ib.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive bus a for one cycle: ld, din, set, clr, push, pop.
  task automatic drv_a(input logic [1:0] ld, input logic [1:0] din, input logic [1:0] set,
                       input logic [1:0] clr, input logic push, input logic pop);
    ia.FLG_LD = ld; ia.DIN = din; ia.FLG_SET = set; ia.FLG_CLR = clr;
    ia.SHAD_PUSH = push; ia.SHAD_POP = pop;
    step();
    ia.FLG_LD = '0; ia.DIN = '0; ia.FLG_SET = '0; ia.FLG_CLR = '0;
    ia.SHAD_PUSH = 1'b0; ia.SHAD_POP = 1'b0;
  endtask

  task automatic drv_b(input logic [1:0] ld, input logic [1:0] din, input logic [1:0] set,
                       input logic [1:0] clr, input logic push, input logic pop);
    ib.FLG_LD = ld; ib.DIN = din; ib.FLG_SET = set; ib.FLG_CLR = clr;
    ib.SHAD_PUSH = push; ib.SHAD_POP = pop;
    step();
    ib.FLG_LD = '0; ib.DIN = '0; ib.FLG_SET = '0; ib.FLG_CLR = '0;
    ib.SHAD_PUSH = 1'b0; ib.SHAD_POP = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ia.FLG_LD = '0; ia.DIN = '0; ia.FLG_SET = '0; ia.FLG_CLR = '0;
    ia.SHAD_PUSH = 1'b1; ia.SHAD_POP = 1'b0;  // reset must override a push
    ib.FLG_LD = '0; ib.DIN = '0; ib.FLG_SET = '0; ib.FLG_CLR = '0;
    ib.SHAD_PUSH = 1'b0; ib.SHAD_POP = 1'b0;
    step();
    step();
    ia.SHAD_PUSH = 1'b0;
    rst = 1'b0;
    chk("rst_flags", 8'(ia.FLAGS), 8'h0);
    chk("rst_lvl", 8'(ia.SHAD_LVL), 8'h0);
    chk("rst_empty", 8'(ia.SHAD_EMPTY), 8'h1);
    chk("rst_full", 8'(ia.SHAD_FULL), 8'h0);
    chk("rst_err", 8'(ia.SHAD_ERR), 8'h0);

    // 1: load, set, clear priority
    drv_a(2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    chk("ld_10", 8'(ia.FLAGS), 8'h2);
    drv_a(2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0);
    chk("set_01", 8'(ia.FLAGS), 8'h3);
    drv_a(2'b00, 2'b00, 2'b01, 2'b01, 1'b0, 1'b0);
    chk("clr_wins_set", 8'(ia.FLAGS), 8'h2);
    drv_a(2'b11, 2'b11, 2'b00, 2'b10, 1'b0, 1'b0);
    chk("clr_wins_ld", 8'(ia.FLAGS), 8'h1);

    // 2: single push / pop
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("p1_lvl", 8'(ia.SHAD_LVL), 8'h1);
    chk("p1_empty", 8'(ia.SHAD_EMPTY), 8'h0);
    chk("p1_flags", 8'(ia.FLAGS), 8'h1);
    drv_a(2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    chk("p1_ld", 8'(ia.FLAGS), 8'h2);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("pop1_flags", 8'(ia.FLAGS), 8'h1);
    chk("pop1_lvl", 8'(ia.SHAD_LVL), 8'h0);
    chk("pop1_empty", 8'(ia.SHAD_EMPTY), 8'h1);
    chk("pop1_err", 8'(ia.SHAD_ERR), 8'h0);

    // 3: nested pushes save pre-update flags 01,10,11,00
    drv_a(2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("n1_flags", 8'(ia.FLAGS), 8'h2);
    drv_a(2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0);
    drv_a(2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("n3_full", 8'(ia.SHAD_FULL), 8'h0);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("n4_lvl", 8'(ia.SHAD_LVL), 8'h4);
    chk("n4_full", 8'(ia.SHAD_FULL), 8'h1);
    chk("n4_err", 8'(ia.SHAD_ERR), 8'h0);
    drv_a(2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("ovf_lvl", 8'(ia.SHAD_LVL), 8'h4);
    chk("ovf_err", 8'(ia.SHAD_ERR), 8'h1);
    chk("ovf_flags", 8'(ia.FLAGS), 8'h1);
    drv_a(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b1);  // pop ignores load
    chk("pop_a", 8'(ia.FLAGS), 8'h0);
    chk("pop_a_lvl", 8'(ia.SHAD_LVL), 8'h3);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("pop_b", 8'(ia.FLAGS), 8'h3);
    drv_a(2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1);  // pop ignores clear
    chk("pop_c", 8'(ia.FLAGS), 8'h2);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("pop_d", 8'(ia.FLAGS), 8'h1);
    chk("pop_d_empty", 8'(ia.SHAD_EMPTY), 8'h1);

    // 4: underflow
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_err", 8'(ia.SHAD_ERR), 8'h0);
    drv_a(2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 1'b1);
    chk("udf_flags", 8'(ia.FLAGS), 8'h2);
    chk("udf_lvl", 8'(ia.SHAD_LVL), 8'h0);
    chk("udf_err", 8'(ia.SHAD_ERR), 8'h1);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("udf_push_lvl", 8'(ia.SHAD_LVL), 8'h1);
    chk("udf_sticky1", 8'(ia.SHAD_ERR), 8'h1);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("udf_pop_flags", 8'(ia.FLAGS), 8'h2);
    chk("udf_sticky2", 8'(ia.SHAD_ERR), 8'h1);

    // 5: push+pop conflict at level 2
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv_a(2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
    drv_a(2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0);  // stack[0]=10
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);  // stack[1]=01
    chk("c_lvl2", 8'(ia.SHAD_LVL), 8'h2);
    chk("c_err0", 8'(ia.SHAD_ERR), 8'h0);
    drv_a(2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 1'b1);
    chk("conf_lvl", 8'(ia.SHAD_LVL), 8'h2);
    chk("conf_err", 8'(ia.SHAD_ERR), 8'h1);
    chk("conf_flags", 8'(ia.FLAGS), 8'h3);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("conf_pop1", 8'(ia.FLAGS), 8'h1);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("conf_pop2", 8'(ia.FLAGS), 8'h2);

    // 6b: reset mid-nesting, with a push held during reset
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    drv_a(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0);
    chk("mid_lvl3", 8'(ia.SHAD_LVL), 8'h3);
    rst = 1'b1;
    drv_a(2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 1'b0);
    rst = 1'b0;
    chk("mid_rst_lvl", 8'(ia.SHAD_LVL), 8'h0);
    chk("mid_rst_flags", 8'(ia.FLAGS), 8'h0);
    chk("mid_rst_err", 8'(ia.SHAD_ERR), 8'h0);
    chk("mid_rst_empty", 8'(ia.SHAD_EMPTY), 8'h1);

    // 6a: CLR_ON_PUSH instance
    drv_b(2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0);
    chk("b_ld", 8'(ib.FLAGS), 8'h3);
    drv_b(2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0);
    chk("b_push_flags", 8'(ib.FLAGS), 8'h0);
    chk("b_push_lvl", 8'(ib.SHAD_LVL), 8'h1);
    drv_b(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
    chk("b_pop_top", 8'(ib.FLAGS), 8'h3);
    chk("b_pop_lvl", 8'(ib.SHAD_LVL), 8'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flag_shadow_stack.md
Name: flag_shadow_stack

Overview:
- Parametrised CPU status-flag register (C, Z, ...) with a LIFO shadow stack for nested interrupts.
- ALU results load the live flags.
- Interrupt entry pushes the live flags onto the stack; RETI pops them back.
- Sits between the ALU flag outputs and the control unit / branch logic, replacing the per-flag register, shadow register and restore mux.

Parameters:
- NFLAGS, 2, number of flag bits (bit 0 = C, bit 1 = Z by convention).
- DEPTH, 4, shadow stack entries (max interrupt nesting depth); must be >= 1.
- CLR_ON_PUSH, 0, when 1, a push also clears all live flags in the same cycle.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RST  in  1  synchronous reset, active-high.
- DIN  in  NFLAGS  flag values from the ALU.
- FLG_LD  in  NFLAGS  per-flag load enable: FLAGS[i] <= DIN[i].
- FLG_SET  in  NFLAGS  per-flag set (e.g. SEC).
- FLG_CLR  in  NFLAGS  per-flag clear (e.g. CLC).
- SHAD_PUSH  in  1  interrupt entry: save live flags.
- SHAD_POP  in  1  RETI: restore flags from top of stack.
- FLAGS  out  NFLAGS  live flag register.
- SHAD_LVL  out  $clog2(DEPTH+1)  number of valid stack entries.
- SHAD_EMPTY  out  1  SHAD_LVL == 0.
- SHAD_FULL  out  1  SHAD_LVL == DEPTH.
- SHAD_ERR  out  1  sticky overflow/underflow/conflict indicator.

Behaviour:
- Reset (RST=1 at the edge):
  - FLAGS=0, SHAD_LVL=0, SHAD_EMPTY=1, SHAD_FULL=0, SHAD_ERR=0.
  - Stack array contents are don't-care.
  - RST overrides every other input.
- Latency: all outputs are registered; effects appear after the edge that samples the request. SHAD_EMPTY and SHAD_FULL are decoded from the registered level, so they have no extra cycle.
- Per-flag update when no pop occurs this cycle:
  - priority is FLG_CLR > FLG_SET > FLG_LD > hold;
  - each bit is independent.
- Push (SHAD_PUSH=1, SHAD_POP=0, not full):
  - stack[SHAD_LVL] <= FLAGS value before this edge, i.e. the pre-update value;
  - SHAD_LVL increments.
  - Same-cycle FLG_* updates still apply to FLAGS.
  - If CLR_ON_PUSH=1, FLAGS <= 0, overriding FLG_*.
- Pop (SHAD_POP=1, SHAD_PUSH=0, not empty):
  - FLAGS <= stack[SHAD_LVL-1]; SHAD_LVL decrements;
  - FLG_LD/SET/CLR are ignored that cycle.
- Overflow (push while SHAD_FULL):
  - push dropped; stack and level unchanged; SHAD_ERR <= 1;
  - FLG_* updates still apply.
- Underflow (pop while SHAD_EMPTY):
  - no restore, level stays 0, SHAD_ERR <= 1;
  - FLG_* updates apply as if no pop had been requested.
- Push and pop in the same cycle:
  - both ignored; stack and level unchanged; SHAD_ERR <= 1;
  - FLG_* updates apply.
- SHAD_ERR clears only on RST.
- Level arithmetic never wraps: it saturates at 0 and DEPTH through the error rules above.
- DEPTH=1 degenerates to a single shadow register with FULL/EMPTY tracking.

Test Plan:
1. Reset, then FLG_LD=2'b11 with DIN=2'b10 -> FLAGS=2'b10 next cycle; FLG_SET=01 and FLG_CLR=01 together -> FLAGS[0]=0 (clear wins).
2. FLAGS=2'b01, PUSH -> LVL=1, EMPTY=0. Then FLG_LD with DIN=2'b10 -> FLAGS=2'b10. Then POP -> FLAGS=2'b01, LVL=0, EMPTY=1.
3. Nested push/pop:
   - Push 01, 10, 11, 00 (DEPTH=4) -> FULL=1.
   - A fifth push -> LVL stays 4, ERR=1, stack unchanged.
   - Four pops -> FLAGS sequence 00, 11, 10, 01.
4. Reset, then POP while empty with FLG_SET=2'b10 -> FLAGS=2'b10, LVL=0, ERR=1. ERR stays 1 across further valid ops until RST.
5. PUSH+POP in the same cycle with LVL=2 -> LVL=2, ERR=1, FLAGS follows FLG_* only. Also: a POP with FLG_LD active -> FLAGS equals the popped value, not DIN.
6. CLR_ON_PUSH=1, FLAGS=2'b11, PUSH with FLG_SET=2'b01 -> FLAGS=0, stack top=2'b11. Also: RST asserted mid-nesting (LVL=3) -> LVL=0, FLAGS=0, ERR=0 next cycle.
